// File: rtl/ima_adpcm_decoder.sv
// IMA ADPCM (mono) streaming decoder.
// Takes 16-bit little-endian words from the fetch path over valid/ready and
// emits signed 16-bit PCM over valid/ready. Each block is a predictor word, an
// index word, then data words holding four nibbles each, low nibble first.
module ima_adpcm_decoder #(
  parameter int BLOCK_ALIGN = 512
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        block_start
);

  // Data nibbles per block; always a multiple of 4 because BLOCK_ALIGN is even.
  localparam int NIBBLES = 2 * (BLOCK_ALIGN - 4);
  localparam int CW      = $clog2(NIBBLES + 1);

  typedef enum logic [2:0] {HDR0, HDR1, FETCH, DECODE, EMIT} state_t;

  state_t             state, state_nx;
  logic               live;       // low for the first cycle out of reset
  logic [15:0]        word_q;
  logic [1:0]         nib_sel;
  logic [CW-1:0]      nib_left;
  logic signed [15:0] predictor;
  logic [6:0]         index;

  logic               take;       // word handshake this cycle
  logic               give;       // sample handshake this cycle
  logic [3:0]         nib;
  logic [14:0]        step;
  logic [16:0]        diff;
  logic signed [17:0] p_wide;
  logic signed [15:0] p_sat;
  logic signed [8:0]  adj;
  logic signed [8:0]  idx_wide;
  logic [6:0]         idx_nx;
  logic [6:0]         hdr_idx;

  // Standard 89-entry IMA step table.
  function automatic logic [14:0] step_lut(input logic [6:0] i);
    logic [14:0] s;
    case (i)
      7'd0:  s = 15'd7;     7'd1:  s = 15'd8;     7'd2:  s = 15'd9;     7'd3:  s = 15'd10;
      7'd4:  s = 15'd11;    7'd5:  s = 15'd12;    7'd6:  s = 15'd13;    7'd7:  s = 15'd14;
      7'd8:  s = 15'd16;    7'd9:  s = 15'd17;    7'd10: s = 15'd19;    7'd11: s = 15'd21;
      7'd12: s = 15'd23;    7'd13: s = 15'd25;    7'd14: s = 15'd28;    7'd15: s = 15'd31;
      7'd16: s = 15'd34;    7'd17: s = 15'd37;    7'd18: s = 15'd41;    7'd19: s = 15'd45;
      7'd20: s = 15'd50;    7'd21: s = 15'd55;    7'd22: s = 15'd60;    7'd23: s = 15'd66;
      7'd24: s = 15'd73;    7'd25: s = 15'd80;    7'd26: s = 15'd88;    7'd27: s = 15'd97;
      7'd28: s = 15'd107;   7'd29: s = 15'd118;   7'd30: s = 15'd130;   7'd31: s = 15'd143;
      7'd32: s = 15'd157;   7'd33: s = 15'd173;   7'd34: s = 15'd190;   7'd35: s = 15'd209;
      7'd36: s = 15'd230;   7'd37: s = 15'd253;   7'd38: s = 15'd279;   7'd39: s = 15'd307;
      7'd40: s = 15'd337;   7'd41: s = 15'd371;   7'd42: s = 15'd408;   7'd43: s = 15'd449;
      7'd44: s = 15'd494;   7'd45: s = 15'd544;   7'd46: s = 15'd598;   7'd47: s = 15'd658;
      7'd48: s = 15'd724;   7'd49: s = 15'd796;   7'd50: s = 15'd876;   7'd51: s = 15'd963;
      7'd52: s = 15'd1060;  7'd53: s = 15'd1166;  7'd54: s = 15'd1282;  7'd55: s = 15'd1411;
      7'd56: s = 15'd1552;  7'd57: s = 15'd1707;  7'd58: s = 15'd1878;  7'd59: s = 15'd2066;
      7'd60: s = 15'd2272;  7'd61: s = 15'd2499;  7'd62: s = 15'd2749;  7'd63: s = 15'd3024;
      7'd64: s = 15'd3327;  7'd65: s = 15'd3660;  7'd66: s = 15'd4026;  7'd67: s = 15'd4428;
      7'd68: s = 15'd4871;  7'd69: s = 15'd5358;  7'd70: s = 15'd5894;  7'd71: s = 15'd6484;
      7'd72: s = 15'd7132;  7'd73: s = 15'd7845;  7'd74: s = 15'd8630;  7'd75: s = 15'd9493;
      7'd76: s = 15'd10442; 7'd77: s = 15'd11487; 7'd78: s = 15'd12635; 7'd79: s = 15'd13899;
      7'd80: s = 15'd15289; 7'd81: s = 15'd16818; 7'd82: s = 15'd18500; 7'd83: s = 15'd20350;
      7'd84: s = 15'd22385; 7'd85: s = 15'd24623; 7'd86: s = 15'd27086; 7'd87: s = 15'd29794;
      default: s = 15'd32767;
    endcase
    return s;
  endfunction

  assign hdr_idx = (word_data[6:0] > 7'd88) ? 7'd88 : word_data[6:0];

  // Nibble decode: step lookup, difference, saturating predictor, index update.
  always_comb begin
    case (nib_sel)
      2'd0:    nib = word_q[3:0];
      2'd1:    nib = word_q[7:4];
      2'd2:    nib = word_q[11:8];
      default: nib = word_q[15:12];
    endcase
    step = step_lut(index);
    diff = {2'b00, step} >> 3;
    if (nib[2]) diff = diff + {2'b00, step};
    if (nib[1]) diff = diff + ({2'b00, step} >> 1);
    if (nib[0]) diff = diff + ({2'b00, step} >> 2);
    p_wide = {{2{predictor[15]}}, predictor};
    if (nib[3]) p_wide = p_wide - $signed({1'b0, diff});
    else        p_wide = p_wide + $signed({1'b0, diff});
    if (p_wide > 18'sd32767)       p_sat = 16'sh7FFF;
    else if (p_wide < -18'sd32768) p_sat = 16'sh8000;
    else                           p_sat = p_wide[15:0];
    case (nib[2:0])
      3'd4:    adj = 9'sd2;
      3'd5:    adj = 9'sd4;
      3'd6:    adj = 9'sd6;
      3'd7:    adj = 9'sd8;
      default: adj = -9'sd1;
    endcase
    idx_wide = $signed({2'b00, index}) + adj;
    if (idx_wide < 9'sd0)       idx_nx = 7'd0;
    else if (idx_wide > 9'sd88) idx_nx = 7'd88;
    else                        idx_nx = idx_wide[6:0];
  end

  // State register.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) state <= HDR0;
    else          state <= state_nx;
  end

  // Next state and handshake outputs; nothing advances while enable is low.
  always_comb begin
    state_nx     = state;
    word_ready   = 1'b0;
    sample_valid = 1'b0;
    block_start  = 1'b0;
    take         = 1'b0;
    give         = 1'b0;
    case (state)
      HDR0: begin
        word_ready  = enable & live;
        take        = word_ready & word_valid;
        block_start = take;
        if (take) state_nx = HDR1;
      end
      HDR1: begin
        word_ready = enable & live;
        take       = word_ready & word_valid;
        if (take) state_nx = EMIT;
      end
      FETCH: begin
        word_ready = enable & live;
        take       = word_ready & word_valid;
        if (take) state_nx = DECODE;
      end
      DECODE: begin
        if (enable) state_nx = EMIT;
      end
      EMIT: begin
        sample_valid = 1'b1;
        give         = enable & sample_ready;
        if (give) begin
          if (nib_left == '0)      state_nx = HDR0;
          else if (nib_sel != 2'd3) state_nx = DECODE;
          else                     state_nx = FETCH;
        end
      end
      default: state_nx = HDR0;
    endcase
  end

  // Datapath registers: header capture, word latch, decode result, nibble walk.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      live        <= 1'b0;
      word_q      <= '0;
      nib_sel     <= '0;
      nib_left    <= '0;
      predictor   <= '0;
      index       <= '0;
      sample_data <= '0;
    end else begin
      live <= 1'b1;
      if (enable) begin
        case (state)
          HDR0: if (take) predictor <= word_data;
          HDR1: if (take) begin
            index       <= hdr_idx;
            sample_data <= predictor;
            nib_sel     <= 2'd3;          // header sample is followed by a fetch
            nib_left    <= CW'(NIBBLES);
          end
          FETCH: if (take) begin
            word_q  <= word_data;
            nib_sel <= 2'd0;
          end
          DECODE: begin
            predictor   <= p_sat;
            sample_data <= p_sat;
            index       <= idx_nx;
            nib_left    <= nib_left - CW'(1);
          end
          EMIT: if (give && nib_left != '0 && nib_sel != 2'd3) nib_sel <= nib_sel + 2'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ima_adpcm_decoder.sv
// Scoreboard bench for ima_adpcm_decoder with 8-byte blocks (9 samples/block).
// Words are queued with their expected samples from a reference decoder;
// the monitor pops and compares on every sample handshake.
module tb_ima_adpcm_decoder;
  localparam int BA  = 8;
  localparam int NIB = 2 * (BA - 4);

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        block_start;

  int errs = 0, checks = 0;
  int n_out = 0, bs_cnt = 0;
  logic w_hs = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [16:0] wq[$];     // {is_predictor_word, word}

  int step_tab[89] = '{7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
    107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408,
    449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552,
    1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871,
    5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
  int idx_adj[8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  always #10 clk50 = ~clk50;

  ima_adpcm_decoder #(.BLOCK_ALIGN(BA)) dut (
    .clk50(clk50), .reset_n(reset_n), .enable(enable),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .block_start(block_start)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference decode of one block; queues its words and expected samples.
  task automatic push_block(input logic [15:0] pred, input logic [15:0] w1,
                            input logic [15:0] d0, input logic [15:0] d1);
    int p, ix, st, df;
    logic [3:0] nb;
    logic [15:0] dw;
    p  = int'($signed(pred));
    ix = (w1[6:0] > 7'd88) ? 88 : int'(w1[6:0]);
    wq.push_back({1'b1, pred});
    wq.push_back({1'b0, w1});
    wq.push_back({1'b0, d0});
    wq.push_back({1'b0, d1});
    exp_q.push_back(pred);
    for (int k = 0; k < NIB; k++) begin
      dw = (k < 4) ? d0 : d1;
      nb = dw[4*(k%4) +: 4];
      st = step_tab[ix];
      df = st >> 3;
      if (nb[2]) df += st;
      if (nb[1]) df += st >> 1;
      if (nb[0]) df += st >> 2;
      p = nb[3] ? p - df : p + df;
      if (p > 32767)  p = 32767;
      if (p < -32768) p = -32768;
      ix += idx_adj[nb[2:0]];
      if (ix < 0)  ix = 0;
      if (ix > 88) ix = 88;
      exp_q.push_back(p[15:0]);
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && c < 3000) begin
      @(posedge clk50);
      c++;
    end
    chk(tag, 32'(exp_q.size() + wq.size()), 0);
  endtask

  // Monitor: handshakes are decided by the values seen at the falling edge.
  always @(negedge clk50) begin
    if (!reset_n) begin
      w_hs <= 1'b0;
    end else begin
      if (sample_valid && sample_ready && enable) begin
        if (exp_q.size() == 0) chk("extra_smp", 32'(exp_q.size()), 1);
        else                   chk("sample", sample_data, exp_q.pop_front());
        obs_q.push_back(sample_data);
        n_out++;
      end
      if (block_start) bs_cnt++;
      if (word_valid && word_ready && wq.size() > 0) begin
        chk("bstart", block_start, wq[0][16]);
        w_hs <= 1'b1;
      end else begin
        if (block_start) chk("bstart_idle", block_start, 0);
        w_hs <= 1'b0;
      end
    end
  end

  // Word driver.
  initial forever begin
    @(posedge clk50);
    #1;
    if (w_hs && wq.size() > 0) void'(wq.pop_front());
    if (reset_n && wq.size() > 0) begin
      word_valid = 1'b1;
      word_data  = wq[0][15:0];
    end else begin
      word_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, c, bs0;
    logic [15:0] held;
    logic sv0;

    // Reset state
    #5;
    chk("rst_wready", word_ready, 0);
    chk("rst_svalid", sample_valid, 0);
    chk("rst_sdata", sample_data, 0);
    chk("rst_bstart", block_start, 0);
    repeat (3) @(posedge clk50);
    #2;
    reset_n = 1'b1;
    enable = 1'b1;
    sample_ready = 1'b1;

    // T1 basic
    b = obs_q.size();
    push_block(16'h0000, 16'h0000, 16'h0007, 16'h0000);
    drain("t1_drain");
    chk("t1_s0", obs_q[b+0], 16'd0);
    chk("t1_s1", obs_q[b+1], 16'd11);
    chk("t1_s2", obs_q[b+2], 16'd13);
    chk("t1_s3", obs_q[b+3], 16'd14);
    chk("t1_s4", obs_q[b+4], 16'd15);
    chk("t1_s8", obs_q[b+8], 16'd19);

    // T2 saturation
    b = obs_q.size();
    push_block(16'h7FF0, 16'd88, 16'h00F7, 16'h0000);
    drain("t2_drain");
    chk("t2_s0", obs_q[b+0], 16'h7FF0);
    chk("t2_s1", obs_q[b+1], 16'h7FFF);
    chk("t2_s2", obs_q[b+2], 16'h9003);
    chk("t2_s3", obs_q[b+3], 16'hA002);

    // T3 header index clamp
    b = obs_q.size();
    push_block(16'h1000, 16'h00FF, 16'h0000, 16'h0000);
    drain("t3_drain");
    chk("t3_s1", obs_q[b+1], 16'h1FFF);
    chk("t3_s2", obs_q[b+2], 16'h2E8B);

    // Most negative predictor driven further down
    push_block(16'h8000, 16'd40, 16'h8888, 16'hFFFF);
    drain("neg_drain");

    // T5 back-to-back blocks
    bs0 = bs_cnt;
    push_block(16'h0123, 16'd10, 16'h1234, 16'h5678);
    push_block(16'hFEDC, 16'd60, 16'h9ABC, 16'hDEF0);
    drain("t5_drain");
    chk("t5_bstarts", 32'(bs_cnt - bs0), 2);

    // T4 backpressure mid-word
    b = n_out;
    push_block(16'h0400, 16'd20, 16'h7316, 16'hC5A2);
    c = 0;
    while (n_out < b + 3 && c < 200) begin @(posedge clk50); c++; end
    #1;
    sample_ready = 1'b0;
    c = 0;
    do begin @(negedge clk50); c++; end while (!sample_valid && c < 20);
    held = sample_data;
    repeat (10) begin
      @(negedge clk50);
      chk("t4_valid", sample_valid, 1);
      chk("t4_hold", sample_data, held);
      chk("t4_wready", word_ready, 0);
    end
    @(posedge clk50);
    #1;
    sample_ready = 1'b1;
    drain("t4_drain");

    // Enable low freezes mid-block
    b = n_out;
    push_block(16'hF000, 16'd30, 16'h2B4D, 16'h6E81);
    c = 0;
    while (n_out < b + 4 && c < 200) begin @(posedge clk50); c++; end
    #1;
    enable = 1'b0;
    @(negedge clk50);
    sv0 = sample_valid;
    repeat (6) begin
      @(negedge clk50);
      chk("en_wready", word_ready, 0);
      chk("en_svalid", sample_valid, sv0);
    end
    @(posedge clk50);
    #1;
    enable = 1'b1;
    drain("en_drain");

    // Random blocks
    for (int r = 0; r < 4; r++)
      push_block(16'($urandom), 16'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
    drain("rnd_drain");

    // T6 reset during EMIT of sample 3
    b = n_out;
    push_block(16'h2222, 16'd15, 16'h4321, 16'h8765);
    c = 0;
    while (n_out < b + 2 && c < 200) begin @(posedge clk50); c++; end
    c = 0;
    do begin @(posedge clk50); #3; c++; end while (!sample_valid && c < 20);
    reset_n = 1'b0;
    #1;
    chk("t6_svalid", sample_valid, 0);
    chk("t6_sdata", sample_data, 0);
    chk("t6_wready", word_ready, 0);
    chk("t6_bstart", block_start, 0);
    repeat (2) @(posedge clk50);
    exp_q.delete();
    wq.delete();
    @(posedge clk50);
    #2;
    reset_n = 1'b1;
    bs0 = bs_cnt;
    b = obs_q.size();
    push_block(16'h5A5A, 16'd5, 16'h1F2E, 16'h3D4C);
    drain("t6_drain");
    chk("t6_hdr", obs_q[b], 16'h5A5A);
    chk("t6_bstarts", 32'(bs_cnt - bs0), 1);

    repeat (4) @(posedge clk50);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
